lp_col_ctr: RTL and testbench
=============================

// Module: lp_col_ctr
// PURPOSE
//   Parametrised LP20-family printer column counter with programmable carriage limit,
//   multi-cycle hardware tab expansion and overflow detection.
//   Sits in the LP20 datapath between the character decoder and the printer interface.
//   Tracks print column, emits one space strobe per tab-expanded column, and flags
//   (or wraps on) carriage overflow.
// PARAMETERS
//   CW      8  counter/limit width in bits (2..16)
//   TABSTOP 8  tab stop spacing; power of two, 2..2**(CW-1)
// PORTS
//   clk        in   1   clock
//   rst        in   1   async reset, active high
//   lpINIT     in   1   sync initialize (same effect as rst)
//   lpDATAI    in   36  bus data in; [CW-1:0] used by register writes
//   cctrWRITE  in   1   load regCCTR <= lpDATAI[CW-1:0]
//   limWRITE   in   1   load regLIM  <= lpDATAI[CW-1:0]
//   lpCLRCCTR  in   1   clear column (carriage return)
//   lpINCCCTR  in   1   advance one column (printable char)
//   lpTAB      in   1   start tab expansion to next stop
//   regCCTR    out  CW  current column
//   regLIM     out  CW  last legal column (carriage width - 1)
//   busy       out  1   tab expansion in progress
//   spcSTB     out  1   one-cycle pulse per column emitted by tab expansion
//   ovfl       out  1   sticky: advance attempted with regCCTR == regLIM
//   wrapREQ    out  1   one-cycle pulse: auto-wrap occurred (line feed needed)
// BEHAVIOUR
//   - Reset/lpINIT: regCCTR=0, regLIM={CW{1'b1}}, busy=0, spcSTB=0, ovfl=0, wrapREQ=0; FSM->IDLE.
//   - All updates registered; outputs change the cycle after the qualifying input.
//   - Priority per cycle: lpINIT > lpCLRCCTR > cctrWRITE > tab step > lpINCCCTR.
//   - limWRITE independent of the above; takes effect for the next cycle's compare.
//   - lpCLRCCTR: regCCTR=0, ovfl=0, FSM->IDLE (aborts tab). cctrWRITE: load, ovfl=0, FSM->IDLE.
//   - "Advance" (from lpINCCCTR or tab step):
//     regCCTR<regLIM -> regCCTR+1 (CW-bit, no carry out);
//     regCCTR>=regLIM -> overflow event (see CONFIGURATION). Limit 0 => every advance overflows.
//   - FSM IDLE: lpTAB (no higher-priority event) -> TAB, busy=1 next cycle. lpINCCCTR advances.
//   - FSM TAB: each cycle one advance + spcSTB=1; lpINCCCTR and lpTAB ignored.
//     Leaves TAB (busy=0 next cycle) when the post-advance column is a multiple of TABSTOP,
//     or on an overflow event. Tab from a stop always moves >= 1 column (0 -> 8 emits 8 spcSTB).
//   - Tab stop test: low log2(TABSTOP) bits of next column == 0; wrap 2**CW-1 -> 0 ends tab.
//   - spcSTB never asserted in IDLE; wrapREQ and spcSTB are never both high.
//   - rst mid-tab: immediate abort, all outputs to reset values asynchronously.
// CONFIGURATION
//   LP_COL_CTR_AUTOWRAP_EN
//     defined:   overflow event -> regCCTR=0, wrapREQ pulse 1 cycle, ovfl=1; tab ends.
//     undefined: overflow event -> regCCTR holds at current value (saturate), ovfl=1;
//                wrapREQ tied 0; tab ends.
// TESTING
//   1 rst, then lpINCCCTR x5 -> regCCTR=5, ovfl=0, busy=0, regLIM=8'hFF.
//   2 regCCTR=3, lpTAB 1 cycle -> busy 5 cycles, 5 spcSTB pulses, regCCTR=8, busy=0.
//   3 limWRITE 10, regCCTR=10, lpINCCCTR -> undefined macro: regCCTR=10, ovfl=1;
//     defined: regCCTR=0, wrapREQ 1 cycle, ovfl=1.
//   4 limWRITE 12, regCCTR=9, lpTAB -> 3 spcSTB to 12, 4th step overflows; tab ends, ovfl=1.
//   5 mid-tab (regCCTR=2 from 0) lpCLRCCTR -> regCCTR=0, busy=0, no further spcSTB; same
//     with cctrWRITE 0x21 -> regCCTR=0x21; lpINCCCTR during tab ignored.
//   6 lpINIT + cctrWRITE + lpINCCCTR same cycle -> regCCTR=0; async rst mid-tab -> all reset.

Source files
------------

// File: rtl/lp_col_ctr.sv
// lp_col_ctr -- LP20-family printer column counter.
//
// Tracks the print column between the character decoder and the printer
// interface. It provides a programmable carriage limit and multi-cycle
// hardware tab expansion. It also detects carriage overflow: an advance
// attempted while the column is already at the limit.
//
// Build option (macro LP_COL_CTR_AUTOWRAP_EN):
//   defined   - an overflow wraps the column to 0 and pulses wrapREQ.
//   undefined - an overflow leaves the column where it is; wrapREQ stays 0.
//   In both builds an overflow sets the sticky ovfl flag and ends any tab.
//
// Parameters:
//   CW       counter/limit width in bits (2..16)
//   TABSTOP  tab stop spacing, a power of two (2..2**(CW-1))
//
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   lpINIT     synchronous initialise (same effect as rst)
//   lpDATAI    36-bit bus data; only [CW-1:0] is used by register writes
//   cctrWRITE  load the column from lpDATAI
//   limWRITE   load the limit from lpDATAI
//   lpCLRCCTR  carriage return: clear the column and abort any tab
//   lpINCCCTR  advance one column for a printable character
//   lpTAB      start tab expansion to the next stop
//   regCCTR    current column
//   regLIM     last legal column (carriage width - 1)
//   busy       tab expansion in progress
//   spcSTB     one-cycle pulse per column emitted by tab expansion
//   ovfl       sticky carriage-overflow flag
//   wrapREQ    one-cycle pulse when an auto-wrap occurred (line feed needed)
module lp_col_ctr #(
  parameter int CW      = 8,
  parameter int TABSTOP = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lpINIT,
  input  logic [35:0]   lpDATAI,
  input  logic          cctrWRITE,
  input  logic          limWRITE,
  input  logic          lpCLRCCTR,
  input  logic          lpINCCCTR,
  input  logic          lpTAB,
  output logic [CW-1:0] regCCTR,
  output logic [CW-1:0] regLIM,
  output logic          busy,
  output logic          spcSTB,
  output logic          ovfl,
  output logic          wrapREQ
);

  localparam int TAB_BITS = $clog2(TABSTOP);

  typedef enum logic {IDLE = 1'b0, TAB = 1'b1} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cctr_next, lim_next, col_plus1, data_word;
  logic          spc_next, ovfl_next, wrap_next, do_advance;
  logic          unused_data_bits;

  assign data_word        = lpDATAI[CW-1:0];
  assign unused_data_bits = ^lpDATAI[35:CW];
  assign col_plus1        = regCCTR + 1'b1;
  assign busy             = (state == TAB);

  // Next-state and next-output logic. Priority order:
  //   lpINIT > lpCLRCCTR > cctrWRITE > tab step > lpINCCCTR.
  // A tab start in IDLE outranks a same-cycle printable character.
  // limWRITE is independent of this chain; only lpINIT overrides it.
  always_comb begin
    state_next = state;
    cctr_next  = regCCTR;
    lim_next   = regLIM;
    ovfl_next  = ovfl;
    spc_next   = 1'b0;
    wrap_next  = 1'b0;
    do_advance = 1'b0;

    if (limWRITE) lim_next = data_word;

    if (lpINIT) begin
      state_next = IDLE;
      cctr_next  = '0;
      lim_next   = '1;
      ovfl_next  = 1'b0;
    end else if (lpCLRCCTR) begin
      state_next = IDLE;
      cctr_next  = '0;
      ovfl_next  = 1'b0;
    end else if (cctrWRITE) begin
      state_next = IDLE;
      cctr_next  = data_word;
      ovfl_next  = 1'b0;
    end else if (state == TAB) begin
      do_advance = 1'b1;
    end else if (lpTAB) begin
      state_next = TAB;
    end else if (lpINCCCTR) begin
      do_advance = 1'b1;
    end

    // A column strictly below the limit advances normally, so the
    // increment can never carry out of CW bits. At or past the limit
    // the advance becomes an overflow event instead, which never
    // produces a space strobe; this keeps spcSTB and wrapREQ exclusive.
    if (do_advance) begin
      if (regCCTR < regLIM) begin
        cctr_next = col_plus1;
        if (state == TAB) begin
          spc_next = 1'b1;
          if (col_plus1[TAB_BITS-1:0] == '0) state_next = IDLE;
        end
      end else begin
        ovfl_next  = 1'b1;
        state_next = IDLE;
`ifdef LP_COL_CTR_AUTOWRAP_EN
        cctr_next  = '0;
        wrap_next  = 1'b1;
`else
        cctr_next  = regCCTR;
        wrap_next  = 1'b0;
`endif
      end
    end
  end

  // State and output registers; an asynchronous reset aborts any tab at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      regCCTR <= '0;
      regLIM  <= '1;
      spcSTB  <= 1'b0;
      ovfl    <= 1'b0;
      wrapREQ <= 1'b0;
    end else begin
      state   <= state_next;
      regCCTR <= cctr_next;
      regLIM  <= lim_next;
      spcSTB  <= spc_next;
      ovfl    <= ovfl_next;
      wrapREQ <= wrap_next;
    end
  end

endmodule

// File: tb/tb_lp_col_ctr.sv
// tb_lp_col_ctr -- directed, table-driven bench for lp_col_ctr (CW=8, TABSTOP=8).
// Expected values are hand-computed. The LP_COL_CTR_AUTOWRAP_EN macro
// selects which overflow outcome the bench expects.
module tb_lp_col_ctr;

  localparam int CW = 8;
`ifdef LP_COL_CTR_AUTOWRAP_EN
  localparam bit AW = 1'b1;
`else
  localparam bit AW = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          lpINIT, cctrWRITE, limWRITE, lpCLRCCTR, lpINCCCTR, lpTAB;
  logic [35:0]   lpDATAI;
  logic [CW-1:0] regCCTR, regLIM;
  logic          busy, spcSTB, ovfl, wrapREQ;

  int nVec = 0;
  int nErr = 0;

  typedef struct {
    logic          init, clr, cw, lw, inc, tab;
    logic [35:0]   data;
    logic [CW-1:0] eCctr, eLim;
    logic          eBusy, eSpc, eOvfl, eWrap;
  } vec_t;

  vec_t vecs[$];

  lp_col_ctr #(.CW(CW), .TABSTOP(8)) dut (
    .clk(clk), .rst(rst), .lpINIT(lpINIT), .lpDATAI(lpDATAI),
    .cctrWRITE(cctrWRITE), .limWRITE(limWRITE), .lpCLRCCTR(lpCLRCCTR),
    .lpINCCCTR(lpINCCCTR), .lpTAB(lpTAB), .regCCTR(regCCTR), .regLIM(regLIM),
    .busy(busy), .spcSTB(spcSTB), .ovfl(ovfl), .wrapREQ(wrapREQ)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Builds one vector record: inputs first, then expected outputs.
  function automatic vec_t mk(input logic init, clr, cw, lw, inc, tab,
                              input logic [35:0] data,
                              input logic [CW-1:0] eCctr, eLim,
                              input logic eBusy, eSpc, eOvfl, eWrap);
    vec_t v;
    v.init = init; v.clr = clr; v.cw = cw; v.lw = lw; v.inc = inc; v.tab = tab;
    v.data = data; v.eCctr = eCctr; v.eLim = eLim;
    v.eBusy = eBusy; v.eSpc = eSpc; v.eOvfl = eOvfl; v.eWrap = eWrap;
    return v;
  endfunction

  // Compares one output field and reports a mismatch.
  task automatic checkField(input string tag, input int idx,
                            input logic [CW-1:0] act, input logic [CW-1:0] exp);
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s vec %0d: got %0h, expected %0h", tag, idx, act, exp);
    end
  endtask

  // Compares every DUT output against a vector's expected values.
  task automatic checkOutput(input int idx, input vec_t v);
    nVec++;
    checkField("regCCTR", idx, regCCTR, v.eCctr);
    checkField("regLIM",  idx, regLIM,  v.eLim);
    checkField("busy",    idx, CW'(busy),    CW'(v.eBusy));
    checkField("spcSTB",  idx, CW'(spcSTB),  CW'(v.eSpc));
    checkField("ovfl",    idx, CW'(ovfl),    CW'(v.eOvfl));
    checkField("wrapREQ", idx, CW'(wrapREQ), CW'(v.eWrap));
  endtask

  // Drives one vector's inputs for one clock and samples 1 unit after the edge.
  task automatic applyStimulus(input int idx, input vec_t v);
    lpINIT = v.init; lpCLRCCTR = v.clr; cctrWRITE = v.cw; limWRITE = v.lw;
    lpINCCCTR = v.inc; lpTAB = v.tab; lpDATAI = v.data;
    @(posedge clk);
    #1;
    checkOutput(idx, v);
  endtask

  initial begin
    vec_t rv;
    vec_t idle;

    // Reset state expected after rst or lpINIT.
    rv   = mk(0,0,0,0,0,0, 36'h0, 8'h00, 8'hFF, 0,0,0,0);
    idle = mk(0,0,0,0,0,0, 36'h0, 8'h00, 8'hFF, 0,0,0,0);

    // Printable characters from reset.
    for (int i = 1; i <= 5; i++) vecs.push_back(mk(0,0,0,0,1,0, 36'h0, CW'(i), 8'hFF, 0,0,0,0));
    // Tab from column 3: five strobes, ending at 8.
    vecs.push_back(mk(0,0,1,0,0,0, 36'h3, 8'd3, 8'hFF, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 36'h0, 8'd3, 8'hFF, 1,0,0,0));
    for (int c = 4; c <= 7; c++) vecs.push_back(mk(0,0,0,0,0,0, 36'h0, CW'(c), 8'hFF, 1,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 36'h0, 8'd8, 8'hFF, 0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 36'h0, 8'd8, 8'hFF, 0,0,0,0));
    // Limit 10: 9->10 is legal; the next advance overflows.
    vecs.push_back(mk(0,0,0,1,0,0, 36'd10, 8'd8, 8'd10, 0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0, 36'd9, 8'd9, 8'd10, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0, 36'h0, 8'd10, 8'd10, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0, 36'h0, AW ? 8'd0 : 8'd10, 8'd10, 0,0,1,AW));
    vecs.push_back(mk(0,0,0,0,0,0, 36'h0, AW ? 8'd0 : 8'd10, 8'd10, 0,0,1,0));
    // Limit 12, tab from 9: three strobes, then overflow ends the tab.
    vecs.push_back(mk(0,0,0,1,0,0, 36'd12, AW ? 8'd0 : 8'd10, 8'd12, 0,0,1,0));
    vecs.push_back(mk(0,0,1,0,0,0, 36'd9, 8'd9, 8'd12, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 36'h0, 8'd9, 8'd12, 1,0,0,0));
    for (int c = 10; c <= 12; c++) vecs.push_back(mk(0,0,0,0,0,0, 36'h0, CW'(c), 8'd12, 1,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 36'h0, AW ? 8'd0 : 8'd12, 8'd12, 0,0,1,AW));
    vecs.push_back(mk(0,0,0,0,0,0, 36'h0, AW ? 8'd0 : 8'd12, 8'd12, 0,0,1,0));
    // Carriage return aborts a tab; limWRITE in the same cycle still applies.
    vecs.push_back(mk(0,1,0,1,0,0, 36'hFF, 8'd0, 8'hFF, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 36'h0, 8'd0, 8'hFF, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 36'h0, 8'd1, 8'hFF, 1,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 36'h0, 8'd2, 8'hFF, 1,1,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 36'h0, 8'd0, 8'hFF, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 36'h0, 8'd0, 8'hFF, 0,0,0,0));
    // A column write aborts a tab; lpINCCCTR during the tab is ignored.
    vecs.push_back(mk(0,0,0,0,0,1, 36'h0, 8'd0, 8'hFF, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0, 36'h0, 8'd1, 8'hFF, 1,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 36'h0, 8'd2, 8'hFF, 1,1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0, 36'h21, 8'h21, 8'hFF, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 36'h0, 8'h21, 8'hFF, 0,0,0,0));
    // Limit 0 makes every advance overflow; lpINIT then beats cctrWRITE and lpINCCCTR.
    vecs.push_back(mk(0,0,0,1,0,0, 36'h0, 8'h21, 8'h00, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0, 36'h0, AW ? 8'h00 : 8'h21, 8'h00, 0,0,1,AW));
    vecs.push_back(mk(1,0,1,0,1,0, 36'h55, 8'h00, 8'hFF, 0,0,0,0));
    // Tab from a stop: 0 -> 8 emits eight strobes.
    vecs.push_back(mk(0,0,0,0,0,1, 36'h0, 8'd0, 8'hFF, 1,0,0,0));
    for (int c = 1; c <= 7; c++) vecs.push_back(mk(0,0,0,0,0,0, 36'h0, CW'(c), 8'hFF, 1,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 36'h0, 8'd8, 8'hFF, 0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 36'h0, 8'd8, 8'hFF, 0,0,0,0));

    lpINIT = 0; lpCLRCCTR = 0; cctrWRITE = 0; limWRITE = 0;
    lpINCCCTR = 0; lpTAB = 0; lpDATAI = '0;
    rst = 1'b1;
    #2;
    checkOutput(-1, rv);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);

    // Asynchronous reset in the middle of a tab, without waiting for a clock edge.
    applyStimulus(100, mk(0,0,1,0,0,0, 36'h5, 8'd5, 8'hFF, 0,0,0,0));
    applyStimulus(101, mk(0,0,0,0,0,1, 36'h0, 8'd5, 8'hFF, 1,0,0,0));
    applyStimulus(102, mk(0,0,0,0,0,0, 36'h0, 8'd6, 8'hFF, 1,1,0,0));
    #3;
    rst = 1'b1;
    #1;
    checkOutput(103, rv);
    #2;
    rst = 1'b0;
    applyStimulus(104, idle);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
